pio_led_out_ext: RTL and testbench

- Parametrised successor to the single-register Avalon-MM LED output port.
- Adds configurable width, atomic set/clear/toggle, per-bit hardware blink with a programmable period, and global PWM brightness.
- Sits on the system interconnect as a zero-wait-state slave and drives board LEDs directly.

---
 rtl/pio_led_out_ext.sv | 119 +++++++++++
 tb/tb_pio_led_out_ext.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pio_led_out_ext.sv
// Avalon-MM LED output port with atomic set/clear/toggle, per-bit blink and PWM brightness.
// Zero-wait-state slave; readdata is combinational, out_port is registered.
module pio_led_out_ext #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0,
  parameter int unsigned           PRESCALE_W  = 24,
  parameter int unsigned           PWM_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  typedef enum logic [2:0] {
    REG_DATA         = 3'd0,
    REG_SET          = 3'd1,
    REG_CLEAR        = 3'd2,
    REG_TOGGLE       = 3'd3,
    REG_BLINK_MASK   = 3'd4,
    REG_BLINK_PERIOD = 3'd5,
    REG_DUTY         = 3'd6,
    REG_OUT          = 3'd7
  } reg_addr_e;

  reg_addr_e             addr;
  logic                  wr;
  logic [WIDTH-1:0]      wd_w;
  logic [PRESCALE_W-1:0] wd_p;
  logic [PWM_W-1:0]      wd_d;
  logic                  unused_wd;

  logic [WIDTH-1:0]      data_q;
  logic [WIDTH-1:0]      mask_q;
  logic [PRESCALE_W-1:0] period_q;
  logic [PWM_W-1:0]      duty_q;
  logic [PRESCALE_W-1:0] blink_cnt_q;
  logic                  phase_q;
  logic [PWM_W-1:0]      pwm_cnt_q;
  logic                  pwm_on;
  logic [WIDTH-1:0]      out_next;

  assign addr      = reg_addr_e'(address);
  assign wr        = chipselect & ~write_n;
  assign wd_w      = writedata[WIDTH-1:0];
  assign wd_p      = writedata[PRESCALE_W-1:0];
  assign wd_d      = writedata[PWM_W-1:0];
  assign unused_wd = ^writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= RESET_VALUE;
      mask_q   <= '0;
      period_q <= '0;
      duty_q   <= '1;
    end else if (wr) begin
      unique case (addr)
        REG_DATA:         data_q   <= wd_w;
        REG_SET:          data_q   <= data_q | wd_w;
        REG_CLEAR:        data_q   <= data_q & ~wd_w;
        REG_TOGGLE:       data_q   <= data_q ^ wd_w;
        REG_BLINK_MASK:   mask_q   <= wd_w;
        REG_BLINK_PERIOD: period_q <= wd_p;
        REG_DUTY:         duty_q   <= wd_d;
        REG_OUT:          ;
      endcase
    end
  end

  // A BLINK_PERIOD write restarts the phase and wins over any reload/toggle due this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else if (wr && addr == REG_BLINK_PERIOD) begin
      blink_cnt_q <= wd_p;
      phase_q     <= 1'b1;
    end else if (period_q == '0) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else if (blink_cnt_q == '0) begin
      blink_cnt_q <= period_q;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q - PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pwm_cnt_q <= '0;
    else       pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
  end

  always_comb begin
    pwm_on   = (pwm_cnt_q < duty_q) || (duty_q == '1);
    out_next = (data_q & ~(mask_q & ~{WIDTH{phase_q}})) & {WIDTH{pwm_on}};
  end

  always_ff @(posedge clk) begin
    if (reset) out_port <= '0;
    else       out_port <= out_next;
  end

  always_comb begin
    readdata = '0;
    unique case (addr)
      REG_DATA, REG_SET, REG_CLEAR, REG_TOGGLE: readdata[WIDTH-1:0] = data_q;
      REG_BLINK_MASK:   readdata[WIDTH-1:0]      = mask_q;
      REG_BLINK_PERIOD: readdata[PRESCALE_W-1:0] = period_q;
      REG_DUTY:         readdata[PWM_W-1:0]      = duty_q;
      REG_OUT:          readdata[WIDTH-1:0]      = out_port;
    endcase
  end

endmodule

// File: tb/tb_pio_led_out_ext.sv
// Bench for pio_led_out_ext: directed plan steps plus random bus traffic against a
// cycle-count based reference model of the blink/PWM/register behaviour.
module tb_pio_led_out_ext;

  localparam logic [7:0] RV = 8'h3C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int unsigned checks = 0;
  int unsigned errors = 0;

  pio_led_out_ext #(
    .WIDTH(8),
    .RESET_VALUE(RV),
    .PRESCALE_W(24),
    .PWM_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  always #20 clk = ~clk;

  // Reference model: register contents plus edges elapsed since reset / last period load.
  logic [7:0]  m_data = RV;
  logic [7:0]  m_mask = '0;
  logic [23:0] m_period = '0;
  logic [7:0]  m_duty = 8'hFF;
  logic [7:0]  m_out = '0;
  int unsigned since_load = 0;
  int unsigned since_rst = 0;

  function automatic logic m_phase();
    if (m_period == 0) return 1'b1;
    return ((since_load / (int'(m_period) + 1)) % 2) == 0;
  endfunction

  function automatic logic m_pwm_on();
    int unsigned cnt;
    cnt = since_rst % 256;
    return (cnt < int'(m_duty)) || (m_duty == 8'hFF);
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0, 3'd1, 3'd2, 3'd3: return {24'h0, m_data};
      3'd4:    return {24'h0, m_mask};
      3'd5:    return {8'h0, m_period};
      3'd6:    return {24'h0, m_duty};
      default: return {24'h0, m_out};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic step(input logic rst, input logic cs, input logic wn,
                      input logic [2:0] a, input logic [31:0] wd);
    logic [7:0] e;
    @(negedge clk);
    reset = rst; chipselect = cs; write_n = wn; address = a; writedata = wd;
    @(posedge clk);
    if (rst) begin
      e = '0;
      m_data = RV; m_mask = '0; m_period = '0; m_duty = 8'hFF;
      since_load = 0; since_rst = 0;
    end else begin
      e = m_data & ~(m_mask & ~{8{m_phase()}}) & {8{m_pwm_on()}};
      since_load++;
      since_rst++;
      if (cs && !wn) begin
        case (a)
          3'd0: m_data = wd[7:0];
          3'd1: m_data = m_data | wd[7:0];
          3'd2: m_data = m_data & ~wd[7:0];
          3'd3: m_data = m_data ^ wd[7:0];
          3'd4: m_mask = wd[7:0];
          3'd5: begin m_period = wd[23:0]; since_load = 0; end
          3'd6: m_duty = wd[7:0];
          default: ;
        endcase
      end
    end
    m_out = e;
    #1;
    chk("out_port", {24'h0, out_port}, {24'h0, e});
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    step(1'b0, 1'b1, 1'b0, a, wd);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
  endtask

  // Combinational read; kept within the first half of the cycle after a step.
  task automatic rdc(input logic [2:0] a, input logic [31:0] want);
    chipselect = 1'b0; write_n = 1'b1; address = a;
    #1;
    chk($sformatf("read_addr%0d", a), readdata, want);
  endtask

  task automatic rd(input logic [2:0] a);
    rdc(a, m_read(a));
  endtask

  initial begin
    int unsigned on_cnt;
    logic [2:0]  ra;
    logic [31:0] rwd;

    // Reset with a write attempt that must be discarded
    step(1'b1, 1'b1, 1'b0, 3'd0, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
    rdc(3'd0, {24'h0, RV});
    rdc(3'd6, 32'h0000_00FF);
    rdc(3'd7, 32'h0);
    idle(1);
    chk("out_after_reset", {24'h0, out_port}, {24'h0, RV});
    rdc(3'd7, {24'h0, RV});

    // Atomic register operations
    wr(3'd0, 32'hFFFF_FFA5); rdc(3'd0, 32'h0000_00A5);
    wr(3'd1, 32'h0000_000F); rdc(3'd1, 32'h0000_00AF);
    wr(3'd2, 32'h0000_0081); rdc(3'd2, 32'h0000_002E);
    wr(3'd3, 32'h0000_00FF); rdc(3'd3, 32'h0000_00D1);
    idle(1);
    rdc(3'd7, 32'h0000_00D1);

    // Blocked writes
    step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0000_0000);
    step(1'b0, 1'b1, 1'b1, 3'd3, 32'h0000_00FF);
    rdc(3'd0, 32'h0000_00D1);

    // Blink: bit0 with half-period 4, then stop mid off-phase
    wr(3'd0, 32'hFF);
    wr(3'd4, 32'h01);
    wr(3'd5, 32'h03);
    idle(5);
    wr(3'd5, 32'h00);
    idle(1);
    chk("blink_stop_bit0", {31'h0, out_port[0]}, 32'h1);
    idle(10);
    for (int unsigned i = 0; i < 8; i++) rd(3'(i));

    // PWM brightness
    wr(3'd4, 32'h00);
    wr(3'd6, 32'd64);
    on_cnt = 0;
    for (int unsigned i = 0; i < 256; i++) begin
      idle(1);
      if (out_port == 8'hFF) on_cnt++;
    end
    chk("pwm_duty64_on_cycles", on_cnt, 32'd64);
    wr(3'd6, 32'd0);
    idle(1);
    on_cnt = 0;
    for (int unsigned i = 0; i < 256; i++) begin
      idle(1);
      if (out_port != 8'h00) on_cnt++;
    end
    chk("pwm_duty0_nonzero_cycles", on_cnt, 32'd0);
    wr(3'd6, 32'd255);
    idle(1);
    on_cnt = 0;
    for (int unsigned i = 0; i < 300; i++) begin
      idle(1);
      if (out_port == 8'h00) on_cnt++;
    end
    chk("pwm_duty255_zero_cycles", on_cnt, 32'd0);

    // Random bus traffic including occasional resets with writes pending
    for (int unsigned i = 0; i < 600; i++) begin
      ra  = 3'($urandom_range(0, 7));
      rwd = (ra == 3'd5) ? 32'($urandom_range(0, 6)) : $urandom;
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0, ra, rwd);
      if (i % 8 == 0) rd(3'($urandom_range(0, 7)));
    end
    for (int unsigned i = 0; i < 8; i++) rd(3'(i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
